// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: the canonical NOP and the fetch entry
// handed from fetch to decode.
package rv32i_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-2 depths (tag FIFO) work too
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && full && !do_pop));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word reads for pc, tags them with their PC,
// buffers returned instructions in order and drops wrong-path responses.
module ifetch_unit
   import rv32i_pkg::*;
#(
   parameter int unsigned BUF_DEPTH       = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        taken,
   output logic        stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned SW = CW + 1;
   localparam int unsigned EW = $bits(fetch_entry_t);

   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] drop_cnt_q, drop_cnt_d;

   logic [31:0]   tag_dout;
   logic          tag_full, tag_empty;
   logic [OW-1:0] tag_count;
   logic [EW-1:0] buf_din, buf_dout;
   logic          buf_full, buf_empty;
   logic [CW-1:0] buf_count;
   logic [SW-1:0] occupancy;
   logic          req_fire, rsp_keep, rsp_drop, buf_push, buf_pop;
   fetch_entry_t  head;

   // Every request reserves a buffer slot, so a response can never find it full
   assign occupancy      = SW'(outstanding_q) + SW'(buf_count);
   assign imem_req_valid = ~rst & ~taken & (outstanding_q < OW'(MAX_OUTSTANDING))
                           & (occupancy < SW'(BUF_DEPTH));
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign stall          = ~req_fire;
   assign imem_req_addr  = {pc[31:2], 2'b00};

   assign rsp_keep = imem_rsp_valid & (drop_cnt_q == '0);
   assign rsp_drop = imem_rsp_valid & (drop_cnt_q != '0);
   assign buf_push = rsp_keep & ~taken;
   assign buf_pop  = if_valid & if_ready & ~taken;
   assign buf_din  = fetch_entry_t'{pc: tag_dout, instr: imem_rsp_data};
   assign head     = fetch_entry_t'(buf_dout);

   assign if_valid = ~buf_empty;
   assign if_instr = buf_empty ? NOP_INSTR : head.instr;
   assign if_pc    = buf_empty ? '0 : head.pc;

   always_comb begin
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);
      if (taken) drop_cnt_d = outstanding_q - OW'(rsp_keep) - OW'(rsp_drop);
      else       drop_cnt_d = drop_cnt_q - OW'(rsp_drop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (req_fire),
      .pop   (imem_rsp_valid),
      .din   (pc),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count)
   );

   fetch_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_ibuf (
      .clk   (clk),
      .rst   (rst),
      .flush (taken),
      .push  (buf_push),
      .pop   (buf_pop),
      .din   (buf_din),
      .dout  (buf_dout),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (outstanding_q == '0 || tag_empty)));
   a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(req_fire && tag_full && !imem_rsp_valid));
   a_buf_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(buf_push && buf_full && !buf_pop));
   a_tag_tracks: assert property (@(posedge clk) disable iff (rst)
      tag_count == outstanding_q);

endmodule
